// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave tone generator with prescaled half-period counter
// Optional attenuation register and amplitude table: define TONE_GEN_ATTEN_EN.
// The "edge" pulse output is named phase_edge because edge is a reserved word.
module tone_gen #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [9:0] wr_data,
  output logic [7:0] tone_out,
  output logic       phase,
  output logic       phase_edge
);

  localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

  logic [7:0]  pre_cnt;
  logic        tick;
  // One bit wider than the period so a loaded 1024 is distinguishable from
  // the post-reset 0, which must reload on the first tick.
  logic [10:0] cnt;
  logic [9:0]  period_reg;
  logic        reload;
  logic        phase_nxt;
  logic        edge_nxt;
  logic [7:0]  amp_level;

  assign tick   = (pre_cnt == PRE_MAX);
  assign reload = tick && (cnt <= 11'd1);

  // Prescaler: free-running 0..PRESCALE-1, never disturbed by writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= 8'd0;
    end else if (tick) begin
      pre_cnt <= 8'd0;
    end else begin
      pre_cnt <= pre_cnt + 8'd1;
    end
  end

  // Half-period down-counter; reloads from the period register as it stands
  // in the reload cycle, so a coincident write applies one reload later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 11'd0;
    end else if (reload) begin
      cnt <= {(period_reg == 10'd0), period_reg};
    end else if (tick) begin
      cnt <= cnt - 11'd1;
    end
  end

  // Next phase/edge: period 1 pins the level high instead of toggling.
  always_comb begin
    phase_nxt = phase;
    edge_nxt  = 1'b0;
    if (reload) begin
      if (period_reg == 10'd1) begin
        phase_nxt = 1'b1;
        edge_nxt  = ~phase;
      end else begin
        phase_nxt = ~phase;
        edge_nxt  = 1'b1;
      end
    end
  end

  // Registered outputs, all updated together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      phase_edge <= 1'b0;
      tone_out   <= 8'h00;
    end else begin
      phase      <= phase_nxt;
      phase_edge <= edge_nxt;
      tone_out   <= phase_nxt ? amp_level : 8'h00;
    end
  end

  // Period register write; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_reg <= 10'd0;
    end else if (wr_en && !wr_sel) begin
      period_reg <= wr_data;
    end
  end

`ifdef TONE_GEN_ATTEN_EN
  logic [3:0] atten_reg;

  // Attenuation register write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      atten_reg <= 4'd0;
    end else if (wr_en && wr_sel) begin
      atten_reg <= wr_data[3:0];
    end
  end

  // Amplitude lookup, roughly -2 dB per step down to silence.
  always_comb begin
    amp_level = 8'd0;
    case (atten_reg)
      4'd0:  amp_level = 8'd255;
      4'd1:  amp_level = 8'd203;
      4'd2:  amp_level = 8'd161;
      4'd3:  amp_level = 8'd128;
      4'd4:  amp_level = 8'd102;
      4'd5:  amp_level = 8'd81;
      4'd6:  amp_level = 8'd64;
      4'd7:  amp_level = 8'd51;
      4'd8:  amp_level = 8'd40;
      4'd9:  amp_level = 8'd32;
      4'd10: amp_level = 8'd26;
      4'd11: amp_level = 8'd20;
      4'd12: amp_level = 8'd16;
      4'd13: amp_level = 8'd13;
      4'd14: amp_level = 8'd10;
      default: amp_level = 8'd0;
    endcase
  end
`else
  assign amp_level = 8'hFF;
`endif

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - self-checking bench for tone_gen against a reload-schedule model
module tb_tone_gen;

  localparam int PRESCALE = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [9:0] wr_data = 10'd0;
  logic [7:0] tone_out;
  logic       phase;
  logic       phase_edge;

  int checks = 0;
  int failures = 0;

  // Model: time in clk edges since reset release and the absolute edge
  // number of the next reload.
  int t;
  int next_reload;
  int m_period;
  int m_atten;
  bit m_phase;
  bit m_edge;
  int m_tone;

  int amp_tab [16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};

  tone_gen #(.PRESCALE(PRESCALE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_sel(wr_sel),
    .wr_data(wr_data),
    .tone_out(tone_out),
    .phase(phase),
    .phase_edge(phase_edge)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  function automatic int high_level(input int atten);
`ifdef TONE_GEN_ATTEN_EN
    return amp_tab[atten];
`else
    return 255 + 0 * atten;
`endif
  endfunction

  // One clk edge with the given inputs, then model update and full check.
  task automatic step(input bit rst, input bit wr, input bit sel, input int data);
    int eff;
    rst_n   = ~rst;
    wr_en   = wr;
    wr_sel  = sel;
    wr_data = data[9:0];
    @(posedge clk);
    if (rst) begin
      t = 0;
      next_reload = PRESCALE;
      m_period = 0;
      m_atten = 0;
      m_phase = 1'b0;
      m_edge = 1'b0;
      m_tone = 0;
    end else begin
      t++;
      m_edge = 1'b0;
      if (t == next_reload) begin
        eff = (m_period == 0) ? 1024 : m_period;
        next_reload = t + eff * PRESCALE;
        if (m_period == 1) begin
          m_edge = !m_phase;
          m_phase = 1'b1;
        end else begin
          m_phase = !m_phase;
          m_edge = 1'b1;
        end
      end
      m_tone = m_phase ? high_level(m_atten) : 0;
      if (wr) begin
        if (!sel) m_period = data & 1023;
`ifdef TONE_GEN_ATTEN_EN
        else m_atten = data & 15;
`endif
      end
    end
    #1;
    chk("phase", phase, m_phase);
    chk("edge", phase_edge, m_edge);
    chk("tone_out", tone_out, m_tone);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Advance so that the next step lands exactly on a reload edge.
  task automatic to_before_reload();
    int guard = 0;
    while (t < next_reload - 1 && guard < 20000) begin
      step(1'b0, 1'b0, 1'b0, 0);
      guard++;
    end
    chk("reload_align", t, next_reload - 1);
  endtask

  initial begin
    t = 0;
    next_reload = PRESCALE;
    m_period = 0;
    m_atten = 0;
    m_phase = 1'b0;
    m_edge = 1'b0;
    m_tone = 0;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);
    chk("reset_phase", phase, 0);
    chk("reset_tone", tone_out, 0);

    // Period 0 after reset: first edge PRESCALE cycles after release.
    idle(PRESCALE - 1);
    chk("pre_first_edge", phase_edge, 0);
    idle(1);
    chk("first_edge", phase_edge, 1);
    chk("first_phase", phase, 1);
    chk("first_tone", tone_out, 255);

    // Next toggle 1024 * PRESCALE cycles later.
    idle(1024 * PRESCALE - 1);
    chk("long_before", phase, 1);
    idle(1);
    chk("long_edge", phase_edge, 1);
    chk("long_phase", phase, 0);

    // Period 2: current half-period runs out, then 32-cycle halves.
    idle($urandom_range(1, 50));
    step(1'b0, 1'b1, 1'b0, 2);
    to_before_reload();
    idle(1);
    chk("p2_switch_edge", phase_edge, 1);
    idle(2 * PRESCALE);
    chk("p2_half_edge", phase_edge, 1);
    idle(4 * PRESCALE);

    // Period 5 written on a reload edge: old value used once more.
    to_before_reload();
    step(1'b0, 1'b1, 1'b0, 5);
    chk("coinc_next", next_reload - t, 2 * PRESCALE);
    idle(2 * PRESCALE);
    chk("coinc_old_edge", phase_edge, 1);
    idle(5 * PRESCALE);
    chk("coinc_new_edge", phase_edge, 1);
    idle(3 * PRESCALE);

    // Period 1: phase pinned high, no further edges.
    step(1'b0, 1'b1, 1'b0, 1);
    idle(12 * PRESCALE);
    chk("p1_phase", phase, 1);
    chk("p1_tone", tone_out, 255);

    // Attenuation levels with a toggling tone.
    step(1'b0, 1'b1, 1'b0, 3);
    for (int k = 0; k < 3; k++) begin
      int a;
      a = (k == 0) ? 0 : ((k == 1) ? 3 : 15);
      step(1'b0, 1'b1, 1'b1, a);
      idle(8 * PRESCALE);
    end

    // Randomized writes and gaps.
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 2) == 0)
        step(1'b0, 1'b1, 1'b1, int'($urandom_range(0, 1023)));
      else
        step(1'b0, 1'b1, 1'b0, int'($urandom_range(1, 6)));
      idle($urandom_range(1, 150));
    end

    // One-cycle reset mid half-period, with a competing write.
    step(1'b0, 1'b1, 1'b0, 4);
    idle($urandom_range(1, 20));
    step(1'b1, 1'b1, 1'b0, 3);
    chk("mid_reset_edge", phase_edge, 0);
    chk("mid_reset_tone", tone_out, 0);
    idle(PRESCALE - 1);
    chk("mid_pre_edge", phase_edge, 0);
    idle(1);
    chk("mid_first_edge", phase_edge, 1);
    idle(3 * PRESCALE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
